// File: rtl/parity_sched.sv
// Round-robin scheduler that serialises two requesters' parity evaluations through a
// shared external 3-input XOR cell, two operand bits per cycle. Optional: PARITY_SCHED_CHK_EN.
module parity_sched #(
  parameter int WIDTH = 8  // must be even and >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
`ifdef PARITY_SCHED_CHK_EN
  input  logic             exp_par0_i,
  input  logic             exp_par1_i,
  output logic             err_o,
`endif
  input  logic             f_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             parity_o,
  output logic             owner_o,
  output logic             x1_o,
  output logic             x2_o,
  output logic             x3_o
);

  localparam int CW = $clog2(WIDTH / 2 + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cur_q, cur_d;
  logic             last_q, last_d;
  logic             parity_q, parity_d;
  logic             owner_q, owner_d;
`ifdef PARITY_SCHED_CHK_EN
  logic             exp_q, exp_d;
`endif

  // Winner: a lone requester wins; on contention, whoever was not served last.
  logic win;
  assign win = (req0_i && req1_i) ? ~last_q : req1_i;

  assign parity_o = parity_q;
  assign owner_o  = owner_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d  = state_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    last_d   = last_q;
    parity_d = parity_q;
    owner_d  = owner_q;
    gnt0_o   = 1'b0;
    gnt1_o   = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    x1_o     = 1'b0;
    x2_o     = 1'b0;
    x3_o     = 1'b0;
`ifdef PARITY_SCHED_CHK_EN
    exp_d    = exp_q;
    err_o    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          cur_d   = win;
          last_d  = win;
          sh_d    = win ? data1_i : data0_i;
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = STEP;
`ifdef PARITY_SCHED_CHK_EN
          exp_d   = win ? exp_par1_i : exp_par0_i;
`endif
        end
      end

      STEP: begin
        busy_o = 1'b1;
        gnt0_o = (cnt_q == '0) && !cur_q;
        gnt1_o = (cnt_q == '0) &&  cur_q;
        x1_o   = acc_q;
        x2_o   = sh_q[1];
        x3_o   = sh_q[0];
        acc_d  = f_i;
        sh_d   = sh_q >> 2;
        cnt_d  = cnt_q + CW'(1);
        // The cell output on the final step is already the full parity.
        if (cnt_q == LAST_STEP) begin
          parity_d = f_i;
          owner_d  = cur_q;
          state_d  = DONE;
        end
      end

      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
`ifdef PARITY_SCHED_CHK_EN
        err_o   = parity_q ^ exp_q;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      cur_q    <= 1'b0;
      last_q   <= 1'b1;  // requester 0 wins the first simultaneous request
      parity_q <= 1'b0;
      owner_q  <= 1'b0;
`ifdef PARITY_SCHED_CHK_EN
      exp_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      parity_q <= parity_d;
      owner_q  <= owner_d;
`ifdef PARITY_SCHED_CHK_EN
      exp_q    <= exp_d;
`endif
    end
  end

endmodule

// File: tb/tb_parity_sched.sv
// Directed + randomized bench for parity_sched; models the external XOR cell and
// predicts grants/parity from the arbitration and parity rules directly.
module tb_parity_sched;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             exp0, exp1;
  logic             f;
  logic             gnt0, gnt1, busy, done, parity, owner, x1, x2, x3;
`ifdef PARITY_SCHED_CHK_EN
  logic             err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit last_m;  // model: requester served last

  always #5 clk = ~clk;

  // Shared external 3-input odd-parity cell.
  assign f = x1 ^ x2 ^ x3;

  parity_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (req0),
    .req1_i    (req1),
    .data0_i   (data0),
    .data1_i   (data1),
`ifdef PARITY_SCHED_CHK_EN
    .exp_par0_i(exp0),
    .exp_par1_i(exp1),
    .err_o     (err),
`endif
    .f_i       (f),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .busy_o    (busy),
    .done_o    (done),
    .parity_o  (parity),
    .owner_o   (owner),
    .x1_o      (x1),
    .x2_o      (x2),
    .x3_o      (x3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, {30'd0, gnt0, gnt1}, 32'd0);
    check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_x"}, {29'd0, x1, x2, x3}, 32'd0);
  endtask

  // One full operation starting in an IDLE cycle; ends in the IDLE cycle after Done.
  task automatic do_op(input bit r0, input bit r1, input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1, input bit e0, input bit e1,
                       input bit hold);
    bit               w;
    bit               ew;
    bit               acc_m;
    logic [WIDTH-1:0] dw;
    req0  = r0;
    req1  = r1;
    data0 = d0;
    data1 = d1;
    exp0  = e0;
    exp1  = e1;
    w     = (r0 && r1) ? !last_m : r1;
    dw    = w ? d1 : d0;
    ew    = w ? e1 : e0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    tick();
    last_m = w;
    // Post-capture changes must not influence the result.
    data0 = WIDTH'($urandom);
    data1 = WIDTH'($urandom);
    exp0  = 1'($urandom);
    exp1  = 1'($urandom);
    if (!hold) begin
      if (w) req1 = 1'b0;
      else   req0 = 1'b0;
    end
    acc_m = 1'b0;
    for (int k = 0; k < WIDTH / 2; k++) begin
      check("gnt0", {31'd0, gnt0}, {31'd0, (k == 0) && !w});
      check("gnt1", {31'd0, gnt1}, {31'd0, (k == 0) && w});
      check("step_busy_done", {30'd0, busy, done}, 32'd2);
      check("step_x", {29'd0, x1, x2, x3}, {29'd0, acc_m, dw[2*k+1], dw[2*k]});
      acc_m = acc_m ^ dw[2*k+1] ^ dw[2*k];
      tick();
    end
    check("done_busy_done", {30'd0, busy, done}, 32'd3);
    check("done_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("done_x", {29'd0, x1, x2, x3}, 32'd0);
    check("parity", {31'd0, parity}, {31'd0, ^dw});
    check("owner", {31'd0, owner}, {31'd0, w});
`ifdef PARITY_SCHED_CHK_EN
    check("err", {31'd0, err}, {31'd0, (^dw) != ew});
`endif
    tick();
    check("after_done", {30'd0, busy, done}, 32'd0);
    check("hold_parity", {30'd0, parity, owner}, {30'd0, ^dw, w});
`ifdef PARITY_SCHED_CHK_EN
    check("err_idle", {31'd0, err}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;
    exp0  = 1'b0;
    exp1  = 1'b0;
    last_m = 1'b1;
    tick();
    tick();
    check_quiet("reset");
    check("reset_par_own", {30'd0, parity, owner}, 32'd0);
    rst = 1'b0;

    // Single request, odd data; both expected-parity values exercised.
    do_op(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0);
    // Even data from requester 1.
    do_op(1'b0, 1'b1, 8'h00, 8'hB4, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 8'hB4, 1'b0, 1'b0, 1'b0);

    // Contention straight from reset: 0 first, then the pending 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m = 1'b1;
    check("rst_par_own", {30'd0, parity, owner}, 32'd0);
    do_op(1'b1, 1'b1, 8'h01, 8'h03, 1'b1, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 8'h01, 8'h03, 1'b1, 1'b0, 1'b0);

    // Fairness: both held for four operations.
    for (int i = 0; i < 4; i++)
      do_op(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;

    // Reset mid-operation after a result with parity=1, owner=1 is on the outputs.
    do_op(1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
    req0  = 1'b1;
    data0 = 8'h07;
    tick();
    check("mid_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m = 1'b1;
    check_quiet("mid_rst");
    check("mid_rst_par_own", {30'd0, parity, owner}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", {31'd0, done}, 32'd0);
    end
    do_op(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b1, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      bit r0;
      bit r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      do_op(r0, r1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
